ula_divisor_sequencial: RTL and testbench

- Sequential restoring unsigned divider. It is the inverse-direction companion to the team's combinational ALU/adder datapath: it undoes multiplication by repeated shift-and-subtract.
- Produces one quotient bit per clock and uses a start/busy/done handshake.
- Sits beside the ALU as a multi-cycle operation unit, driven by the same controller that issues ALU operands.

---
 rtl/ula_divisor_sequencial_if.sv | 13 +
 rtl/ula_divisor_sequencial.sv | 71 +++++++
 tb/tb_ula_divisor_sequencial.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ula_divisor_sequencial_if.sv
// ula_divisor_sequencial_if: start/busy/done handshake and operand/result bus of the sequential divider
interface ula_divisor_sequencial_if #(parameter int N = 4);
  logic         start;
  logic [N-1:0] dividendo;
  logic [N-1:0] divisor;
  logic [N-1:0] quociente;
  logic [N-1:0] resto;
  logic         busy;
  logic         done;
  logic         div_zero;
  modport master (output start, dividendo, divisor, input quociente, resto, busy, done, div_zero);
  modport slave (input start, dividendo, divisor, output quociente, resto, busy, done, div_zero);
endinterface

// File: rtl/ula_divisor_sequencial.sv
// ula_divisor_sequencial: restoring unsigned divider, one quotient bit per clock
module ula_divisor_sequencial #(parameter int N = 4) (
  input logic clk,
  input logic rst,
  ula_divisor_sequencial_if.slave bus
);
  localparam int CW = $clog2(N);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]    state;
  logic [N-1:0]  d, q, quo, res;
  logic [N:0]    r, r_sh, t, r_nx;
  logic [N-1:0]  q_nx;
  logic [CW-1:0] cnt;
  logic          busy_r, done_r, dz_r;
  assign r_sh = {r[N-1:0], q[N-1]};
  assign t    = r_sh - {1'b0, d};
  assign r_nx = t[N] ? r_sh : t;
  assign q_nx = {q[N-2:0], ~t[N]};
  assign bus.quociente = quo;
  assign bus.resto     = res;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.div_zero  = dz_r;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      d      <= '0;
      q      <= '0;
      r      <= '0;
      cnt    <= '0;
      quo    <= '0;
      res    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state == IDLE && bus.start) begin
        if (bus.divisor == '0) begin
          quo    <= '1;
          res    <= bus.dividendo;
          dz_r   <= 1'b1;
          done_r <= 1'b1;
          state  <= DONE;
        end else begin
          d      <= bus.divisor;
          q      <= bus.dividendo;
          r      <= '0;
          cnt    <= '0;
          busy_r <= 1'b1;
          state  <= CALC;
        end
      end else if (state == CALC) begin
        q   <= q_nx;
        r   <= r_nx;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(N - 1)) begin
          quo    <= q_nx;
          res    <= r_nx[N-1:0];
          dz_r   <= 1'b0;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          state  <= DONE;
        end
      end else if (state != IDLE) begin
        state <= IDLE;
      end
    end
endmodule

// File: tb/tb_ula_divisor_sequencial.sv
// tb_ula_divisor_sequencial: randomized and directed checks against an arithmetic reference
module tb_ula_divisor_sequencial;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int fails = 0;
  ula_divisor_sequencial_if #(.N(N)) bus();
  ula_divisor_sequencial #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic void model(input int a, input int b, output int q, output int r, output int z);
    q = (b == 0) ? (1 << N) - 1 : a / b;
    r = (b == 0) ? a : a % b;
    z = (b == 0) ? 1 : 0;
  endfunction

  task automatic run_div(input int a, input int b, output int q, output int r, output int z,
                         output int lat, output int busy_cnt, output int done_cnt);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividendo = N'(a);
    bus.divisor = N'(b);
    @(negedge clk);
    bus.start = 1'b0;
    bus.dividendo = N'($urandom);
    bus.divisor = N'($urandom);
    lat = 0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 1; i <= N + 3; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (lat == 0) lat = i;
      end
      if (i < N + 3) @(negedge clk);
    end
    q = int'(bus.quociente);
    r = int'(bus.resto);
    z = int'(bus.div_zero);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividendo = '0;
    bus.divisor = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.quociente, bus.resto, bus.busy, bus.done, bus.div_zero} !== '0) begin
      fails++;
      $display("FAIL reset: q=%0d r=%0d busy=%b done=%b dz=%b, required all zero",
               bus.quociente, bus.resto, bus.busy, bus.done, bus.div_zero);
    end
    rst = 1'b0;
  endtask

  task automatic check_div(input string name, input int a, input int b);
    int q, r, z, lat, bc, dc, eq, er, ez, elat, ebc;
    run_div(a, b, q, r, z, lat, bc, dc);
    model(a, b, eq, er, ez);
    elat = (b == 0) ? 1 : N + 1;
    ebc = (b == 0) ? 0 : N;
    checks++;
    if (q !== eq || r !== er || z !== ez) begin
      fails++;
      $display("FAIL %s %0d/%0d: q=%0d r=%0d dz=%0d, required q=%0d r=%0d dz=%0d", name, a, b, q, r, z, eq, er, ez);
    end
    checks++;
    if (lat !== elat || bc !== ebc || dc !== 1) begin
      fails++;
      $display("FAIL %s %0d/%0d timing: done_at=%0d busy_cycles=%0d done_pulses=%0d, required %0d %0d 1",
               name, a, b, lat, bc, dc, elat, ebc);
    end
    checks++;
    if (b != 0 && (q * b + r !== a || r >= b)) begin
      fails++;
      $display("FAIL %s invariant %0d/%0d: q=%0d r=%0d", name, a, b, q, r);
    end
  endtask

  task automatic test_nominal();
    check_div("nominal", 13, 3);
  endtask

  task automatic test_extremes();
    check_div("div_by_one", 15, 1);
    check_div("divisor_gt", 3, 7);
    check_div("zero_dividend", 0, 5);
  endtask

  task automatic test_div_zero();
    check_div("div_zero", 7, 0);
    check_div("after_zero", 9, 2);
  endtask

  task automatic test_ignored_start();
    int dc = 0;
    logic [N-1:0] q0, r0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividendo = 4'd14;
    bus.divisor = 4'd4;
    @(negedge clk);
    bus.dividendo = 4'd1;
    bus.divisor = 4'd1;
    for (int i = 0; i < 20 && dc == 0; i++) begin
      if (bus.done) dc++;
      else @(negedge clk);
    end
    @(negedge clk);
    bus.start = 1'b0;
    q0 = bus.quociente;
    r0 = bus.resto;
    checks++;
    if (q0 !== 4'd3 || r0 !== 4'd2) begin
      fails++;
      $display("FAIL ignored_start result: q=%0d r=%0d, required q=3 r=2", q0, r0);
    end
    for (int i = 0; i < 8; i++) begin
      if (bus.done) dc++;
      checks++;
      if (bus.quociente !== q0 || bus.resto !== r0 || bus.busy !== 1'b0) begin
        fails++;
        $display("FAIL ignored_start hold: q=%0d r=%0d busy=%b, required q=3 r=2 busy=0", bus.quociente, bus.resto, bus.busy);
      end
      @(negedge clk);
    end
    checks++;
    if (dc !== 1) begin
      fails++;
      $display("FAIL ignored_start pulses: %0d, required 1", dc);
    end
  endtask

  task automatic test_reset_mid_op();
    int dc = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividendo = 4'd12;
    bus.divisor = 4'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.quociente === 4'd0) begin
      fails++;
      $display("FAIL reset_mid_op precondition: busy=%b q=%0d, required busy=1 q!=0", bus.busy, bus.quociente);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.quociente, bus.resto, bus.busy, bus.done, bus.div_zero} !== '0) begin
      fails++;
      $display("FAIL reset_mid_op async: q=%0d r=%0d busy=%b done=%b dz=%b, required all zero",
               bus.quociente, bus.resto, bus.busy, bus.done, bus.div_zero);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done) dc++;
      @(negedge clk);
    end
    checks++;
    if (dc !== 0) begin
      fails++;
      $display("FAIL reset_mid_op done: pulses=%0d, required 0", dc);
    end
    check_div("after_reset", 12, 5);
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < (1 << N); a++)
      for (int b = 0; b < (1 << N); b++)
        check_div("sweep", a, b);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      check_div("random", int'($urandom_range((1 << N) - 1)), int'($urandom_range((1 << N) - 1)));
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_extremes();
    test_div_zero();
    test_ignored_start();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
